input_symbol_encoder: RTL

- Upstream stage of the symbol-driven automate labs: turns three raw, asynchronous, bouncing push-buttons into clean one-cycle symbol codes a1/a2/a3 (codes 1/2/3) on a 2-bit bus.
- Code 0 means "no symbol".
- Per-button synchronisation, debounce and press detection, plus a pending queue so simultaneous presses are serialised rather than lost.

---
 rtl/input_symbol_pkg.sv | 14 +
 rtl/button_debouncer.sv | 56 +++++
 rtl/input_symbol_encoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/input_symbol_pkg.sv
// Shared symbol codes and sizes for the push-button symbol encoder.
// Codes match the automate input alphabet so downstream stages use them unchanged.
package input_symbol_pkg;

   localparam int unsigned NUM_BTN = 3;

   typedef logic [1:0] symbol_t;

   localparam symbol_t SYM_IDLE = 2'd0;
   localparam symbol_t SYM_A1   = 2'd1;
   localparam symbol_t SYM_A2   = 2'd2;
   localparam symbol_t SYM_A3   = 2'd3;

endpackage

// File: rtl/button_debouncer.sv
// One button: synchroniser chain, saturating-free debounce counter, level register,
// and one-cycle pulses on the edge where the debounced level rises or falls.
module button_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   level_q;
   logic                   synced;
   logic                   differ;
   logic                   toggle;

   assign synced = sync_q[SYNC_STAGES-1];
   assign differ = synced != level_q;
   assign toggle = differ && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   // Any agreeing sample restarts the count, so only an unbroken run toggles the level.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else if (!differ) begin
         cnt_q <= '0;
      end else if (toggle) begin
         cnt_q   <= '0;
         level_q <= ~level_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = level_q;
   assign rise  = toggle & ~level_q;
   assign fall  = toggle & level_q;

endmodule

// File: rtl/input_symbol_encoder.sv
// Three debounced buttons -> serialised one-cycle symbol codes with a1 > a2 > a3 priority.
// Build option INPUT_SYMBOL_AUTOREPEAT_EN adds per-button auto-repeat while held.
module input_symbol_encoder
   import input_symbol_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] btn,
   output logic [1:0] sym,
   output logic       sym_valid,
   output logic [2:0] btn_level
);

   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] fall;
   logic [NUM_BTN-1:0] rep_set;
   logic [NUM_BTN-1:0] pending_q;
   logic [NUM_BTN-1:0] sel_oh;
   symbol_t            sel_code;
   symbol_t            sym_q;
   logic               sym_valid_q;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debouncer #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk    (clk),
         .reset  (reset),
         .btn_raw(btn[i]),
         .level  (btn_level[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

`ifdef INPUT_SYMBOL_AUTOREPEAT_EN
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_repeat
      logic [31:0] cnt_q;
      logic        phase_q;
      logic [31:0] limit;

      assign limit = phase_q ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);
      // Gating with fall suppresses a repeat landing on the release edge.
      assign rep_set[i] = btn_level[i] & ~fall[i] & (cnt_q == limit);

      always_ff @(posedge clk) begin
         if (reset || !btn_level[i] || fall[i]) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
         end else if (cnt_q == limit) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end
`else
   localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
   logic unused_fall;

   assign unused_fall = ^fall;
   assign rep_set     = '0;
`endif

   // Downward scan so the lowest pending index wins.
   always_comb begin
      sel_oh   = '0;
      sel_code = SYM_IDLE;
      for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_code  = symbol_t'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         sym_q       <= SYM_IDLE;
         sym_valid_q <= 1'b0;
      end else begin
         // Set after clear: a press arriving as its bit is served is kept.
         pending_q   <= (pending_q & ~sel_oh) | rise | rep_set;
         sym_q       <= sel_code;
         sym_valid_q <= |pending_q;
      end
   end

   assign sym       = sym_q;
   assign sym_valid = sym_valid_q;

endmodule
